// File: rtl/sd_adc.sv
// rtl/sd_adc.sv - sigma-delta ADC front end: comparator sync, 1-bit feedback, boxcar decimator, valid/ack output
module sd_adc #(
    parameter int WINLOG2 = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CmpIn,
    input  logic       Enable,
    output logic       FbOut,
    output logic [7:0] ADCout,
    output logic       ADCvalid,
    input  logic       ADCack,
    output logic       Overrun
);

    localparam logic [WINLOG2-1:0] CNT_LAST = '1;

    logic               sync1_q, sync2_q, fb_q;
    logic [WINLOG2-1:0] cnt_q, cnt_d;
    logic [WINLOG2:0]   acc_q, acc_d, sum;
    logic [7:0]         out_q, out_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               win_end;

    always_comb begin
        sum     = acc_q + (WINLOG2+1)'(fb_q);
        win_end = Enable && (cnt_q == CNT_LAST);
        cnt_d   = '0;
        acc_d   = '0;
        out_d   = out_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (Enable) begin
            cnt_d = cnt_q + WINLOG2'(1);
            acc_d = win_end ? '0 : sum;
        end
        if (win_end) begin
            // A full window of ones overflows the 8-bit field, so clamp it.
            out_d   = sum[WINLOG2] ? 8'hFF : sum[WINLOG2-1 -: 8];
            valid_d = 1'b1;
            if (valid_q && !ADCack) begin
                ovr_d = 1'b1;
            end
        end else if (ADCack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fb_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= CmpIn;
            sync2_q <= sync1_q;
            fb_q    <= sync2_q;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign FbOut    = fb_q;
    assign ADCout   = out_q;
    assign ADCvalid = valid_q;
    assign Overrun  = ovr_q;

endmodule

// File: tb/tb_sd_adc.sv
// tb/tb_sd_adc.sv - self-checking bench for sd_adc (WINLOG2 = 8 and 10 instances)
module tb_sd_adc;

    logic       Clk = 1'b0;
    logic       rst, cmp, en, ack8, ack10;
    logic       fb8, v8, ov8, fb10, v10, ov10;
    logic [7:0] out8, out10;

    always #5 Clk = ~Clk;

    sd_adc #(.WINLOG2(8)) dut8 (
        .Clk(Clk), .Reset(rst), .CmpIn(cmp), .Enable(en), .FbOut(fb8),
        .ADCout(out8), .ADCvalid(v8), .ADCack(ack8), .Overrun(ov8)
    );

    sd_adc #(.WINLOG2(10)) dut10 (
        .Clk(Clk), .Reset(rst), .CmpIn(cmp), .Enable(en), .FbOut(fb10),
        .ADCout(out10), .ADCvalid(v10), .ADCack(ack10), .Overrun(ov10)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    // Reference: a 3-deep delay line for the feedback bit, a count of enabled
    // edges and an integer running sum, decimated when the count reaches 2^w.
    typedef struct {
        bit         s1, s2, fb;
        int         n;
        int         sum;
        logic [7:0] out;
        bit         v, ov;
    } model_t;

    model_t m8, m10;

    function automatic model_t model_step(model_t m, int w, bit r, bit c, bit e, bit a);
        model_t nx;
        int     s;
        bit     wend;
        nx = m;
        if (r) begin
            nx = '{default: 0};
            nx.out = 8'h00;
            return nx;
        end
        nx.s1 = c;
        nx.s2 = m.s1;
        nx.fb = m.s2;
        wend  = 0;
        if (!e) begin
            nx.n   = 0;
            nx.sum = 0;
        end else begin
            s = m.sum + int'(m.fb);
            if (m.n + 1 == (1 << w)) begin
                wend   = 1;
                nx.n   = 0;
                nx.sum = 0;
                nx.out = (s == (1 << w)) ? 8'hFF : 8'((s >> (w - 8)) & 255);
            end else begin
                nx.n   = m.n + 1;
                nx.sum = s;
            end
        end
        if (wend) begin
            if (m.v && !a) nx.ov = 1;
            nx.v = 1;
        end else if (a) begin
            nx.v = 0;
        end
        return nx;
    endfunction

    always @(posedge Clk) begin
        m8  = model_step(m8, 8, rst, cmp, en, ack8);
        m10 = model_step(m10, 10, rst, cmp, en, ack10);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            check("model_w8", {20'd0, fb8, out8, v8, ov8}, {20'd0, m8.fb, m8.out, m8.v, m8.ov});
            check("model_w10", {20'd0, fb10, out10, v10, ov10}, {20'd0, m10.fb, m10.out, m10.v, m10.ov});
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic bit pat(input int mode, input int k);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return k[0];
            default: return (k % 4) != 3;
        endcase
    endfunction

    typedef struct {
        string      name;
        int         mode;
        logic [7:0] e8;
        logic [7:0] e10;
    } vec_t;

    vec_t tbl[4];

    initial begin
        bit seen;
        tbl[0] = '{"const0", 0, 8'h00, 8'h00};
        tbl[1] = '{"const1", 1, 8'hFF, 8'hFF};
        tbl[2] = '{"toggle", 2, 8'h80, 8'h80};
        tbl[3] = '{"three_of_four", 3, 8'hC0, 8'hC0};

        m8 = '{default: 0};
        m10 = '{default: 0};
        rst = 1; cmp = 0; en = 0; ack8 = 0; ack10 = 0;
        ticks(2);
        chk_on = 1;
        check("reset_state", {20'd0, fb8, out8, v8, ov8}, 32'd0);

        // First window after release loses 3 ones to the feedback latency.
        cmp = 1; en = 1; ack10 = 1;
        tick();
        rst = 0;
        ticks(255);
        check("first_win_not_early", v8, 1'b0);
        tick();
        check("first_win_valid", v8, 1'b1);
        check("first_win_fd", out8, 8'hFD);
        ack8 = 1; tick(); ack8 = 0;
        check("ack_clears", v8, 1'b0);
        ticks(255);
        check("second_win_valid", v8, 1'b1);
        check("second_win_sat", out8, 8'hFF);
        ack8 = 1; tick(); ack8 = 0;

        // Withhold ack across two windows; second sample differs from first.
        ticks(255);
        check("ovr_win1_valid", v8, 1'b1);
        check("ovr_win1_no_ovr", ov8, 1'b0);
        cmp = 0;
        ticks(256);
        check("ovr_set", ov8, 1'b1);
        check("ovr_new_sample", out8, 8'h03);

        // Reset mid-operation with CmpIn high.
        cmp = 1; rst = 1;
        tick();
        check("midreset_zero", {20'd0, fb8, out8, v8, ov8}, 32'd0);
        tick();
        rst = 0;

        // Ack landing exactly on a window-end edge.
        ticks(256);
        check("restart_valid", v8, 1'b1);
        check("restart_fd", out8, 8'hFD);
        ticks(255);
        ack8 = 1; tick(); ack8 = 0;
        check("ack_on_end_valid", v8, 1'b1);
        check("ack_on_end_no_ovr", ov8, 1'b0);
        check("ack_on_end_data", out8, 8'hFF);
        tick();
        ack8 = 1; tick(); ack8 = 0;
        check("late_ack_clears", v8, 1'b0);

        // Enable dropped at Cnt = 100 for 5 cycles.
        rst = 1; tick(); rst = 0;
        ticks(100);
        en = 0;
        ticks(5);
        en = 1;
        seen = 0;
        for (int i = 0; i < 255; i++) begin
            cmp = 1'($urandom);
            tick();
            if (v8) seen = 1;
        end
        check("no_valid_old_boundary", seen, 1'b0);
        tick();
        check("valid_after_reenable", v8, 1'b1);

        // Randomized run against the reference model.
        for (int i = 0; i < 6000; i++) begin
            cmp   = 1'($urandom);
            en    = ($urandom_range(0, 199) != 0);
            ack8  = ($urandom_range(0, 99) == 0);
            ack10 = ($urandom_range(0, 299) == 0);
            rst   = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 0;

        // Table of steady-state patterns; compare second W=10 window.
        foreach (tbl[t]) begin
            rst = 1; en = 1; ack8 = 1; ack10 = 1; cmp = 0;
            tick();
            rst = 0;
            for (int k = 0; k < 2048; k++) begin
                cmp = pat(tbl[t].mode, k);
                tick();
            end
            check({tbl[t].name, "_v10"}, v10, 1'b1);
            check({tbl[t].name, "_w10"}, out10, tbl[t].e10);
            check({tbl[t].name, "_w8"}, out8, tbl[t].e8);
        end

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
